id_ex_hazard_reg: RTL and testbench

- ID/EX pipeline boundary of the pipelined RISC-V core, directly downstream of the control decoder.
- Registers the decoded control bundle into EX.
- Detects load-use hazards from the decoder's Rs1_used/Rs2_used flags and inserts bubbles.
- Flushes on EX redirects and freezes the front end while the data bus is not ready (MIO_ready).

---
 rtl/id_ex_hazard_reg.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use bubble insertion,
// redirect flush and data-bus freeze.
//
// Handshake: the front end advances only while stall_if=0. flush_id=1 tells
// IF/ID to clear on the next edge. While frozen (mem_req & ~MIO_ready), ID/EX
// holds its contents and no new instruction is accepted.
//
// Optional macro HAZARD_PERF_CNT_EN adds the perf_bubbles/perf_freezes counters.
module id_ex_hazard_reg #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_ALUSrc_B,
  input  logic             id_Jump,
  input  logic             id_Branch,
  input  logic             id_BranchN,
  input  logic             id_RegWrite,
  input  logic             id_MemRW,
  input  logic [1:0]       id_MemtoReg,
  input  logic [2:0]       id_ALU_Control,
  input  logic             id_Rs1_used,
  input  logic             id_Rs2_used,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             MIO_ready,
  output logic             ex_ALUSrc_B,
  output logic             ex_Jump,
  output logic             ex_Branch,
  output logic             ex_BranchN,
  output logic             ex_RegWrite,
  output logic             ex_MemRW,
  output logic [1:0]       ex_MemtoReg,
  output logic [2:0]       ex_ALU_Control,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_valid,
  output logic             stall_if,
  output logic             flush_id,
  output logic             mem_wait,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_bubbles,
  output logic [CNT_W-1:0] perf_freezes
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic       alu_src_b;
    logic       jump;
    logic       branch;
    logic       branch_n;
    logic       reg_write;
    logic       mem_rw;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_ctl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

  state_t              state_q, state_d;
  ctrl_t               ex_q, ex_d, id_bundle;
  logic                ex_valid_q, ex_valid_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                to_q, to_d;
  logic                frz, lu;

  // Hazard detection: freeze from the data bus, load-use against the load in EX.
  // id_valid gates everything first so undriven ID fields cannot raise lu.
  always_comb begin
    frz = mem_req & ~MIO_ready;
    lu  = id_valid & ex_valid_q & ex_q.reg_write & (ex_q.mem_to_reg == 2'b01) &
          (ex_q.rd != 5'd0) &
          ((id_Rs1_used & (id_rs1 == ex_q.rd)) | (id_Rs2_used & (id_rs2 == ex_q.rd)));
    id_bundle = '{alu_src_b: id_ALUSrc_B, jump: id_Jump, branch: id_Branch,
                  branch_n: id_BranchN, reg_write: id_RegWrite, mem_rw: id_MemRW,
                  mem_to_reg: id_MemtoReg, alu_ctl: id_ALU_Control,
                  rs1: id_rs1, rs2: id_rs2, rd: id_rd};
  end

  // Pipeline register next value: hold > redirect bubble > load-use bubble > load.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (frz) begin
      ex_d       = ex_q;
      ex_valid_d = ex_valid_q;
    end else if (ex_redirect || lu) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
    end else begin
      ex_d       = id_bundle;
      ex_valid_d = id_valid;
    end
  end

  // Wait FSM and counter: MEM_WAIT lasts while the freeze persists; the counter
  // restarts on entry, stops at the timeout value and fires a single pulse.
  always_comb begin
    state_d = frz ? ST_MEM_WAIT : ST_RUN;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    if (frz) begin
      if (state_q == ST_RUN) begin
        cnt_d = '0;
      end else if ((MEM_TIMEOUT > 0) && (cnt_q == TO_VAL)) begin
        cnt_d = cnt_q;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + WAIT_W'(1);
        to_d  = (MEM_TIMEOUT > 0) && (cnt_d == TO_VAL);
      end
    end
  end

  // State, counter and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      to_q       <= 1'b0;
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign stall_if       = frz | (~ex_redirect & lu);
  assign flush_id       = ~frz & ex_redirect;
  assign mem_wait       = (state_q == ST_MEM_WAIT) & frz;
  assign mem_timeout    = to_q;
  assign ex_valid       = ex_valid_q;
  assign ex_ALUSrc_B    = ex_q.alu_src_b;
  assign ex_Jump        = ex_q.jump;
  assign ex_Branch      = ex_q.branch;
  assign ex_BranchN     = ex_q.branch_n;
  assign ex_RegWrite    = ex_q.reg_write;
  assign ex_MemRW       = ex_q.mem_rw;
  assign ex_MemtoReg    = ex_q.mem_to_reg;
  assign ex_ALU_Control = ex_q.alu_ctl;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign ex_rd          = ex_q.rd;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] bub_q, bub_d, frzc_q, frzc_d;

  // Performance counters: bubble cycles from load-use, and freeze cycles.
  always_comb begin
    bub_d  = bub_q;
    frzc_d = frzc_q;
    if (!frz && !ex_redirect && lu) bub_d = bub_q + CNT_W'(1);
    if (frz) frzc_d = frzc_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_q  <= '0;
      frzc_q <= '0;
    end else begin
      bub_q  <= bub_d;
      frzc_q <= frzc_d;
    end
  end

  assign perf_bubbles = bub_q;
  assign perf_freezes = frzc_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg: directed plus random checks of id_ex_hazard_reg
// against a behavioural model of the ID/EX hazard rules.
module tb_id_ex_hazard_reg;

  localparam int T     = 2;
  localparam int CNT_W = 8;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       id_valid, id_ALUSrc_B, id_Jump, id_Branch, id_BranchN, id_RegWrite, id_MemRW;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_MemtoReg;
  logic [2:0] id_ALU_Control;
  logic       id_Rs1_used, id_Rs2_used, ex_redirect, mem_req, MIO_ready;
  logic       ex_ALUSrc_B, ex_Jump, ex_Branch, ex_BranchN, ex_RegWrite, ex_MemRW;
  logic [1:0] ex_MemtoReg;
  logic [2:0] ex_ALU_Control;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic       ex_valid, stall_if, flush_id, mem_wait, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_bubbles, perf_freezes;
`endif

  id_ex_hazard_reg #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_ALUSrc_B(id_ALUSrc_B), .id_Jump(id_Jump), .id_Branch(id_Branch),
    .id_BranchN(id_BranchN), .id_RegWrite(id_RegWrite), .id_MemRW(id_MemRW),
    .id_MemtoReg(id_MemtoReg), .id_ALU_Control(id_ALU_Control),
    .id_Rs1_used(id_Rs1_used), .id_Rs2_used(id_Rs2_used),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .MIO_ready(MIO_ready),
    .ex_ALUSrc_B(ex_ALUSrc_B), .ex_Jump(ex_Jump), .ex_Branch(ex_Branch),
    .ex_BranchN(ex_BranchN), .ex_RegWrite(ex_RegWrite), .ex_MemRW(ex_MemRW),
    .ex_MemtoReg(ex_MemtoReg), .ex_ALU_Control(ex_ALU_Control),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .stall_if(stall_if), .flush_id(flush_id), .mem_wait(mem_wait),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_bubbles(perf_bubbles), .perf_freezes(perf_freezes)
`endif
  );

  typedef struct packed {
    logic       alu_src_b, jump, branch, branch_n, reg_write, mem_rw;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_ctl;
    logic [4:0] rs1, rs2, rd;
  } bundle_t;

  bundle_t dut_ex;
  assign dut_ex = {ex_ALUSrc_B, ex_Jump, ex_Branch, ex_BranchN, ex_RegWrite, ex_MemRW,
                   ex_MemtoReg, ex_ALU_Control, ex_rs1, ex_rs2, ex_rd};

  // Reference model state
  bundle_t m_ex;
  logic    m_valid;
  int      run;        // consecutive freeze cycles so far
  logic    m_to;       // expected mem_timeout this cycle
  int      m_bub, m_frz;
  int      n_assert, n_fail;

  function automatic bundle_t id_bundle();
    return {id_ALUSrc_B, id_Jump, id_Branch, id_BranchN, id_RegWrite, id_MemRW,
            id_MemtoReg, id_ALU_Control, id_rs1, id_rs2, id_rd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic regw, input logic [1:0] m2r,
                        input logic u1, input logic u2);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_RegWrite = regw; id_MemtoReg = m2r; id_Rs1_used = u1; id_Rs2_used = u2;
    id_ALUSrc_B = 1'($urandom_range(0, 1)); id_Jump = 1'($urandom_range(0, 1));
    id_Branch = 1'($urandom_range(0, 1)); id_BranchN = 1'($urandom_range(0, 1));
    id_MemRW = 1'($urandom_range(0, 1)); id_ALU_Control = 3'($urandom_range(0, 7));
  endtask

  task automatic model_clear();
    m_ex = '0; m_valid = 1'b0; run = 0; m_to = 1'b0; m_bub = 0; m_frz = 0;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk({tag, "_ex"}, 32'(dut_ex), 32'(m_ex));
    chk({tag, "_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, "_wait"}, 32'(mem_wait), 32'd0);
    chk({tag, "_timeout"}, 32'(mem_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_perf_bub"}, 32'(perf_bubbles), 32'd0);
    chk({tag, "_perf_frz"}, 32'(perf_freezes), 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: check outputs at the negedge against the model, then advance it.
  task automatic step(input string tag);
    logic frz, lu, e_stall, e_flush, e_wait;
    int   nrun;
    @(negedge clk);
    frz = mem_req && !MIO_ready;
    lu  = id_valid && m_valid && m_ex.reg_write && (m_ex.mem_to_reg == 2'b01) &&
          (m_ex.rd != 5'd0) &&
          ((id_Rs1_used && id_rs1 == m_ex.rd) || (id_Rs2_used && id_rs2 == m_ex.rd));
    e_stall = frz || (!ex_redirect && lu);
    e_flush = !frz && ex_redirect;
    e_wait  = frz && (run > 0);
    chk({tag, "_ex"}, 32'(dut_ex), 32'(m_ex));
    chk({tag, "_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, "_stall"}, 32'(stall_if), 32'(e_stall));
    chk({tag, "_flush"}, 32'(flush_id), 32'(e_flush));
    chk({tag, "_wait"}, 32'(mem_wait), 32'(e_wait));
    chk({tag, "_timeout"}, 32'(mem_timeout), 32'(m_to));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_perf_bub"}, 32'(perf_bubbles), 32'(m_bub % (1 << CNT_W)));
    chk({tag, "_perf_frz"}, 32'(perf_freezes), 32'(m_frz % (1 << CNT_W)));
`endif
    if (!frz) begin
      if (ex_redirect || lu) begin
        m_ex = '0; m_valid = 1'b0;
      end else begin
        m_ex = id_bundle(); m_valid = id_valid;
      end
    end
    if (!frz && !ex_redirect && lu) m_bub++;
    if (frz) m_frz++;
    nrun = frz ? run + 1 : 0;
    m_to = (nrun == T + 1);
    run  = nrun;
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; MIO_ready = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    do_reset("reset");
    step("idle");

    // Load-use on rs2: one bubble, then the consumer enters EX.
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0); step("lw_x5");
    set_id(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 2'b00, 1'b1, 1'b1); step("lu_add");
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    step("lu_release");
    chk("lu_add_rd", 32'(ex_rd), 32'd6);
    chk("lu_add_valid", 32'(ex_valid), 32'd1);

    // rs2 field matches but is not used: no stall.
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0); step("lw_x5b");
    set_id(1'b1, 5'd1, 5'd5, 5'd7, 1'b1, 2'b00, 1'b1, 1'b0); step("itype");
    chk("itype_rd", 32'(ex_rd), 32'd7);

    // Load to x0 never creates a hazard.
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0); step("lw_x0");
    set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 2'b00, 1'b1, 1'b1); step("use_x0");
    chk("use_x0_valid", 32'(ex_valid), 32'd1);

    // Redirect wins over load-use.
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0); step("lw_x5c");
    set_id(1'b1, 5'd5, 5'd2, 5'd9, 1'b1, 2'b00, 1'b1, 1'b1);
    ex_redirect = 1'b1; step("lu_redirect");
    ex_redirect = 1'b0;
    chk("lu_redirect_valid", 32'(ex_valid), 32'd0);

    // Unknown ID fields with id_valid=0 must not raise a stall.
    set_id(1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0);
    id_valid = 1'b1; step("lw_x5d");
    id_valid = 1'b0; id_rs1 = 'x; id_rs2 = 'x; id_Rs1_used = 1'b1; id_Rs2_used = 1'b1;
    step("x_invalid");
    set_id(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 2'b00, 1'b1, 1'b1); step("after_x");

    // Freeze for three cycles with a timeout of two wait cycles.
    set_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 2'b00, 1'b1, 1'b1); step("pre_frz");
    pulses = 0;
    mem_req = 1'b1; MIO_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'(i + 12), 5'd2, 5'd12, 1'b1, 2'b00, 1'b1, 1'b1);
      step("frz");
      if (mem_timeout === 1'b1) pulses++;
    end
    MIO_ready = 1'b1; step("frz_release");
    if (mem_timeout === 1'b1) pulses++;
    mem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("post_frz");
      if (mem_timeout === 1'b1) pulses++;
    end
    chk("timeout_once", 32'(pulses), 32'd1);

    // Reset in the middle of a freeze.
    mem_req = 1'b1; MIO_ready = 1'b0;
    step("frz_b1"); step("frz_b2");
    mem_req = 1'b0; MIO_ready = 1'b1;
    do_reset("reset_mid_frz");
    step("after_reset");

    // Random traffic biased toward hazards.
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_req     = 1'($urandom_range(0, 1));
      MIO_ready   = ($urandom_range(0, 9) < 6);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
